// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the producer request bus, the serializer load/busy handshake and the
// scheduler status outputs.
//   master : the scheduler side (drives req_ready, tx_frame, tx_load,
//            grant_id, idle, err_timeout; samples req_valid, req_data, tx_busy)
//   slave  : the environment side (producers + serializer), mirror directions
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 8
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH+2:0]         tx_frame;
   logic                          tx_load;
   logic                          tx_busy;
   logic [GW-1:0]                 grant_id;
   logic                          idle;
   logic                          err_timeout;

   modport master (
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_frame, tx_load, grant_id, idle, err_timeout
   );

   modport slave (
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_frame, tx_load, grant_id, idle, err_timeout
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART serializer between NUM_REQ byte producers. Round-robin
// arbitration with a burst allowance of MAX_BURST consecutive grants, builds
// the 11-bit frame (start, data LSB first, even parity, stop), pulses tx_load
// and req_ready for one cycle, then tracks tx_busy with two watchdogs.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - uart_tx_scheduler_if.master: req_valid/req_data/req_ready,
//          tx_frame/tx_load/tx_busy, grant_id, idle, err_timeout (sticky)
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int NUM_REQ      = 2,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_BURST    = 4,
   parameter int ACK_TIMEOUT  = 8,
   parameter int DONE_TIMEOUT = 4096
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_scheduler_if.master bus
);
   localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int TMAX = (DONE_TIMEOUT > ACK_TIMEOUT) ? DONE_TIMEOUT : ACK_TIMEOUT;
   localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int FW   = DATA_WIDTH + 3;

   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] DONE_LAST  = CW'(DONE_TIMEOUT - 1);
   localparam logic [GW-1:0] RR_INIT    = GW'(NUM_REQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

   state_t               r_state,     w_state_nxt;
   logic [CW-1:0]        r_cnt,       w_cnt_nxt;
   logic [BW-1:0]        r_burst_cnt, w_burst_nxt;
   logic [GW-1:0]        r_rr_ptr,    w_rr_nxt;     // also the previous winner
   logic                 r_have_prev, w_have_prev_nxt;
   logic [FW-1:0]        r_frame,     w_frame_nxt;
   logic                 r_load,      w_load_nxt;
   logic [NUM_REQ-1:0]   r_ready,     w_ready_nxt;
   logic [GW-1:0]        r_grant,     w_grant_nxt;
   logic                 r_idle,      w_idle_nxt;
   logic                 r_err,       w_err_nxt;

   logic                  w_keep;
   logic                  w_rr_found;
   logic [GW-1:0]         w_rr_pick;
   logic [GW-1:0]         w_win;
   logic [DATA_WIDTH-1:0] w_data;

   // The previous winner keeps the line only while it still has data and its
   // burst allowance is not used up. r_have_prev is clear after reset so the
   // first grant always comes from the round-robin search (requester 0).
   assign w_keep = r_have_prev && bus.req_valid[r_rr_ptr] && (r_burst_cnt < BURST_LAST);

   // Round-robin search starting one past the previous winner, wrapping.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
      w_rr_found = 1'b0;
      w_rr_pick  = r_rr_ptr;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_rr_found && bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_rr_found = 1'b1;
            w_rr_pick  = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_burst_nxt     = r_burst_cnt;
      w_rr_nxt        = r_rr_ptr;
      w_have_prev_nxt = r_have_prev;
      w_frame_nxt     = r_frame;
      w_load_nxt      = 1'b0;
      w_ready_nxt     = '0;
      w_grant_nxt     = r_grant;
      w_idle_nxt      = r_idle;
      w_err_nxt       = r_err;
      w_win           = r_rr_ptr;
      w_data          = '0;

      case (r_state)
         S_IDLE: begin
            w_idle_nxt = 1'b1;
            if (|bus.req_valid) begin
               if (w_keep) begin
                  w_win       = r_rr_ptr;
                  w_burst_nxt = r_burst_cnt + 1'b1;
               end else begin
                  w_win = w_rr_pick;
                  // Search landing back on the previous winner means it is the
                  // sole requester; its burst count then stays saturated.
                  w_burst_nxt = (r_have_prev && (w_rr_pick == r_rr_ptr)) ? r_burst_cnt : '0;
               end
               w_data          = bus.req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
               w_frame_nxt     = {1'b1, ^w_data, w_data, 1'b0};
               w_load_nxt      = 1'b1;
               w_ready_nxt     = NUM_REQ'(1) << w_win;
               w_grant_nxt     = w_win;
               w_rr_nxt        = w_win;
               w_have_prev_nxt = 1'b1;
               w_idle_nxt      = 1'b0;
               w_cnt_nxt       = '0;
               w_state_nxt     = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT_DONE;
            end else if (r_cnt == ACK_LAST) begin
               w_err_nxt   = 1'b1;
               w_idle_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               w_idle_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == DONE_LAST) begin
               w_err_nxt   = 1'b1;
               w_idle_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_idle_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_burst_cnt <= '0;
         r_rr_ptr    <= RR_INIT;
         r_have_prev <= 1'b0;
         r_frame     <= '1;          // line-idle pattern
         r_load      <= 1'b0;
         r_ready     <= '0;
         r_grant     <= '0;
         r_idle      <= 1'b1;
         r_err       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_have_prev <= w_have_prev_nxt;
         r_frame     <= w_frame_nxt;
         r_load      <= w_load_nxt;
         r_ready     <= w_ready_nxt;
         r_grant     <= w_grant_nxt;
         r_idle      <= w_idle_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign bus.tx_frame    = r_frame;
   assign bus.tx_load     = r_load;
   assign bus.req_ready   = r_ready;
   assign bus.grant_id    = r_grant;
   assign bus.idle        = r_idle;
   assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler: frame/parity format, one-cycle
// ready/load pulses, round-robin with burst limit, sole-requester streaming,
// ack watchdog, and asynchronous reset during a transfer. A small serializer
// model raises tx_busy after each load for busy_len cycles when enabled.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_scheduler_if #(.NUM_REQ(2), .DATA_WIDTH(8)) bus ();

   uart_tx_scheduler #(
      .NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(4), .ACK_TIMEOUT(8), .DONE_TIMEOUT(4096)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   int total = 0;
   int bad   = 0;

   bit model_en  = 1'b1;
   int busy_len  = 20;
   int busy_left = 0;
   int gq[$];
   logic [10:0] fq[$];

   localparam logic [10:0] F11 = 11'b1_0_00010001_0;
   localparam logic [10:0] F22 = 11'b1_0_00100010_0;
   localparam logic [10:0] F3C = 11'b1_0_00111100_0;
   localparam logic [10:0] F5A = 11'b1_0_01011010_0;
   localparam logic [10:0] F81 = 11'b1_0_10000001_0;

   // Serializer model: busy follows a sampled load and lasts busy_len cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.tx_busy <= 1'b0;
         busy_left   <= 0;
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
         if (busy_left == 1) bus.tx_busy <= 1'b0;
      end else if (model_en && bus.tx_load === 1'b1) begin
         bus.tx_busy <= 1'b1;
         busy_left   <= busy_len;
      end
   end

   // Grant monitor.
   always @(negedge clk) begin
      if (!rst && (bus.req_ready !== 2'b00)) begin
         gq.push_back(int'(bus.grant_id));
         fq.push_back(bus.tx_frame);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.req_ready === 2'b00 && n < 60) begin
         step();
         n++;
      end
      check({tag, "_ready_seen"}, 32'(bus.req_ready !== 2'b00), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.idle !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      check({tag, "_idle"}, 32'(bus.idle), 32'd1);
   endtask

   task automatic wait_grants(input int n, input string tag);
      int c = 0;
      while (gq.size() < n && c < 1000) begin
         step();
         c++;
      end
      check({tag, "_count"}, gq.size(), n);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_frame"}, bus.tx_frame,    11'h7FF);
      check({tag, "_load"},  bus.tx_load,     1'b0);
      check({tag, "_ready"}, bus.req_ready,   2'b00);
      check({tag, "_grant"}, bus.grant_id,    1'b0);
      check({tag, "_idle"},  bus.idle,        1'b1);
      check({tag, "_err"},   bus.err_timeout, 1'b0);
   endtask

   task automatic send_single(input string tag, input logic [7:0] d, input logic [10:0] exp_frame);
      bus.req_data  = {8'h00, d};
      bus.req_valid = 2'b01;
      wait_ready(tag);
      check({tag, "_frame"}, bus.tx_frame,  exp_frame);
      check({tag, "_load"},  bus.tx_load,   1'b1);
      check({tag, "_ready"}, bus.req_ready, 2'b01);
      check({tag, "_grant"}, bus.grant_id,  1'b0);
      check({tag, "_busy_idle"}, bus.idle,  1'b0);
      bus.req_valid = 2'b00;
      step();
      check({tag, "_load_off"},  bus.tx_load,   1'b0);
      check({tag, "_ready_off"}, bus.req_ready, 2'b00);
      wait_idle(tag);
      check({tag, "_frame_hold"}, bus.tx_frame, exp_frame);
      check({tag, "_err"}, bus.err_timeout, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      int exp_g[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      bus.req_valid = 2'b00;
      bus.req_data  = '0;

      // Reset state.
      step();
      step();
      check_reset_values("rst");
      rst = 1'b0;
      step();

      // Single request framing and parity.
      send_single("a5",  8'hA5, 11'b1_0_10100101_0);
      send_single("p07", 8'h07, 11'b1_1_00000111_0);
      send_single("p00", 8'h00, 11'b1_0_00000000_0);

      // Both requesters continuously valid: bursts of four.
      do_reset();
      gq.delete();
      fq.delete();
      bus.req_data  = {8'h22, 8'h11};
      bus.req_valid = 2'b11;
      wait_grants(9, "rr");
      bus.req_valid = 2'b00;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("rr_grant%0d", i), (i < gq.size()) ? gq[i] : 32'hFFFF_FFFF, exp_g[i]);
         check($sformatf("rr_frame%0d", i), (i < fq.size()) ? 32'(fq[i]) : 32'hFFFF_FFFF,
               (exp_g[i] == 0) ? 32'(F11) : 32'(F22));
      end
      wait_idle("rr");

      // Sole requester 1: no burst limit.
      gq.delete();
      fq.delete();
      bus.req_data  = {8'h3C, 8'h00};
      bus.req_valid = 2'b10;
      wait_grants(10, "solo");
      bus.req_valid = 2'b00;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("solo_grant%0d", i), (i < gq.size()) ? gq[i] : 32'hFFFF_FFFF, 32'd1);
         check($sformatf("solo_frame%0d", i), (i < fq.size()) ? 32'(fq[i]) : 32'hFFFF_FFFF, 32'(F3C));
      end
      wait_idle("solo");

      // Ack watchdog: busy never rises.
      model_en      = 1'b0;
      bus.req_data  = {8'h00, 8'h5A};
      bus.req_valid = 2'b01;
      wait_ready("to");
      check("to_grant", bus.grant_id, 1'b0);
      check("to_frame", bus.tx_frame, F5A);
      bus.req_valid = 2'b00;
      repeat (7) step();
      check("to_err_early", bus.err_timeout, 1'b0);
      step();
      check("to_err", bus.err_timeout, 1'b1);
      check("to_idle", bus.idle, 1'b1);

      // Next request still served; error stays sticky.
      model_en      = 1'b1;
      bus.req_data  = {8'h81, 8'h00};
      bus.req_valid = 2'b10;
      wait_ready("after_to");
      check("after_to_grant", bus.grant_id,    1'b1);
      check("after_to_ready", bus.req_ready,   2'b10);
      check("after_to_frame", bus.tx_frame,    F81);
      check("after_to_err",   bus.err_timeout, 1'b1);
      bus.req_valid = 2'b00;
      wait_idle("after_to");

      // Reset during WAIT_DONE.
      bus.req_data  = {8'h22, 8'h11};
      bus.req_valid = 2'b11;
      wait_ready("pre_rst");
      check("pre_rst_grant", bus.grant_id, 1'b1);
      repeat (5) step();
      check("pre_rst_busy_idle", bus.idle, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_values("mid_rst");
      step();
      check("in_rst_ready", bus.req_ready, 2'b00);
      rst = 1'b0;
      wait_ready("post_rst");
      check("post_rst_grant", bus.grant_id,  1'b0);
      check("post_rst_ready", bus.req_ready, 2'b01);
      check("post_rst_frame", bus.tx_frame,  F11);
      bus.req_valid = 2'b00;
      wait_idle("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
